line_buffer_ctrl: RTL and testbench

Sequencing controller for the two-bank (ping-pong) RGB line buffer between the PPU pixel stream and the VGA/TMDS scan-out. It generates write addresses and write enables for the pixel producer, with ready/valid backpressure. It hands completed lines to the reader and repeats each line REPEAT times for vertical line doubling. It also reports underruns to the rest of the video path. The block runs in the pclk domain and replaces free-running bank toggling with explicit full/empty ownership of each bank.

---
 rtl/line_buffer_ctrl.sv | 129 ++++++++++++
 tb/tb_line_buffer_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Ping-pong line buffer sequencer: producer write addressing with backpressure,
// reader bank hand-off with line repeat, and underrun reporting.
module line_buffer_ctrl #(
    parameter int unsigned LINE_LEN = 800,
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned REPEAT   = 2
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             wr_en,
    output logic [IDX_W:0]   wr_addr,
    input  logic             rd_line_req,
    input  logic             rd_frame_start,
    output logic [IDX_W:0]   rd_base,
    output logic             rd_line_ok,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);
    localparam logic [1:0]       REP_LAST = 2'(REPEAT - 1);

    logic [1:0]       full, full_n;
    logic             wr_bank, wr_bank_n;
    logic [IDX_W-1:0] wr_idx, wr_idx_n;
    logic             rd_bank, rd_bank_n;
    logic             rd_active, rd_active_n;
    logic [1:0]       rep_cnt, rep_cnt_n;
    logic             rd_line_ok_n;
    logic             underrun_n;
    logic [7:0]       underrun_cnt_n;

    // Reader's view of bank ownership after any frame-start release this cycle
    logic [1:0]       rd_full_view;
    logic             rd_act_view;
    logic             nb;

    assign wr_ready = ~full[wr_bank];
    assign wr_en    = wr_valid & wr_ready;
    assign wr_addr  = {wr_bank, wr_idx};
    assign rd_base  = {rd_bank, {IDX_W{1'b0}}};

    always_comb begin
        full_n         = full;
        wr_bank_n      = wr_bank;
        wr_idx_n       = wr_idx;
        rd_bank_n      = rd_bank;
        rd_active_n    = rd_active;
        rep_cnt_n      = rep_cnt;
        rd_line_ok_n   = rd_line_ok;
        underrun_n     = underrun;
        underrun_cnt_n = underrun_cnt;
        rd_full_view   = full;
        rd_act_view    = rd_active;
        nb             = rd_bank;

        if (wr_en) begin
            if (wr_idx == LAST_IDX) begin
                wr_idx_n        = '0;
                full_n[wr_bank] = 1'b1;
                wr_bank_n       = ~wr_bank;
            end else begin
                wr_idx_n = wr_idx + IDX_W'(1);
            end
        end

        if (rd_frame_start) begin
            if (rd_active) begin
                full_n[rd_bank]       = 1'b0;
                rd_full_view[rd_bank] = 1'b0;
            end
            rd_act_view  = 1'b0;
            rd_active_n  = 1'b0;
            rep_cnt_n    = '0;
            rd_line_ok_n = 1'b0;
        end

        if (rd_line_req) begin
            nb = rd_act_view ? ~rd_bank : rd_bank;
            if (rd_act_view && (rep_cnt < REP_LAST)) begin
                rep_cnt_n    = rep_cnt + 2'd1;
                rd_line_ok_n = 1'b1;
            end else begin
                if (rd_act_view) begin
                    full_n[rd_bank] = 1'b0;
                end
                rd_bank_n = nb;
                rep_cnt_n = '0;
                if (rd_full_view[nb]) begin
                    rd_active_n  = 1'b1;
                    rd_line_ok_n = 1'b1;
                end else begin
                    rd_active_n    = 1'b0;
                    rd_line_ok_n   = 1'b0;
                    underrun_n     = 1'b1;
                    underrun_cnt_n = (underrun_cnt == 8'hFF) ? underrun_cnt
                                                             : underrun_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            full         <= '0;
            wr_bank      <= 1'b0;
            wr_idx       <= '0;
            rd_bank      <= 1'b0;
            rd_active    <= 1'b0;
            rep_cnt      <= '0;
            rd_line_ok   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            full         <= full_n;
            wr_bank      <= wr_bank_n;
            wr_idx       <= wr_idx_n;
            rd_bank      <= rd_bank_n;
            rd_active    <= rd_active_n;
            rep_cnt      <= rep_cnt_n;
            rd_line_ok   <= rd_line_ok_n;
            underrun     <= underrun_n;
            underrun_cnt <= underrun_cnt_n;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: directed scenarios plus random traffic against
// a sequential bank-ownership reference model.
module tb_line_buffer_ctrl;

    localparam int LINE_LEN = 800;
    localparam int IDX_W    = 10;
    localparam int REPEAT   = 2;

    logic             pclk;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_en;
    logic [IDX_W:0]   wr_addr;
    logic             rd_line_req;
    logic             rd_frame_start;
    logic [IDX_W:0]   rd_base;
    logic             rd_line_ok;
    logic             underrun;
    logic [7:0]       underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_full [2];
    int m_wr_bank, m_wr_idx, m_rd_bank, m_rd_active, m_rep, m_ok, m_urun, m_ucnt;
    bit m_wv;

    line_buffer_ctrl #(
        .LINE_LEN (LINE_LEN),
        .IDX_W    (IDX_W),
        .REPEAT   (REPEAT)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .rd_line_req    (rd_line_req),
        .rd_frame_start (rd_frame_start),
        .rd_base        (rd_base),
        .rd_line_ok     (rd_line_ok),
        .underrun       (underrun),
        .underrun_cnt   (underrun_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wr_bank = 0; m_wr_idx = 0; m_rd_bank = 0; m_rd_active = 0;
        m_rep = 0; m_ok = 0; m_urun = 0; m_ucnt = 0;
    endtask

    task automatic check_outputs();
        int exp_ready;
        exp_ready = m_full[m_wr_bank] ? 0 : 1;
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        chk("wr_en", 32'(wr_en), 32'(exp_ready & int'(m_wv)));
        chk("wr_addr", 32'(wr_addr), 32'(m_wr_bank * (2 ** IDX_W) + m_wr_idx));
        chk("rd_base", 32'(rd_base), 32'(m_rd_bank * (2 ** IDX_W)));
        chk("rd_line_ok", 32'(rd_line_ok), 32'(m_ok));
        chk("underrun", 32'(underrun), 32'(m_urun));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    endtask

    // One pclk of bank ownership: frame start, then line request, then writer.
    task automatic model_step(input bit r, input bit wv, input bit lr, input bit fs);
        bit acc;
        int nb;
        if (r) begin
            model_reset();
            return;
        end
        acc = wv && !m_full[m_wr_bank];
        if (fs) begin
            if (m_rd_active != 0) m_full[m_rd_bank] = 1'b0;
            m_rd_active = 0; m_rep = 0; m_ok = 0;
        end
        if (lr) begin
            if (m_rd_active != 0 && m_rep < REPEAT - 1) begin
                m_rep++;
                m_ok = 1;
            end else begin
                nb = (m_rd_active != 0) ? 1 - m_rd_bank : m_rd_bank;
                if (m_rd_active != 0) m_full[m_rd_bank] = 1'b0;
                m_rd_bank = nb;
                m_rep = 0;
                if (m_full[nb]) begin
                    m_rd_active = 1; m_ok = 1;
                end else begin
                    m_rd_active = 0; m_ok = 0; m_urun = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
        end
        if (acc) begin
            m_wr_idx++;
            if (m_wr_idx == LINE_LEN) begin
                m_wr_idx = 0;
                m_full[m_wr_bank] = 1'b1;
                m_wr_bank = 1 - m_wr_bank;
            end
        end
    endtask

    // Drive one cycle at negedge, check everything, advance model, return #1 after posedge.
    task automatic cycle(input bit r, input bit wv, input bit lr, input bit fs);
        @(negedge pclk);
        rst = r; wr_valid = wv; rd_line_req = lr; rd_frame_start = fs; m_wv = wv;
        #1;
        check_outputs();
        model_step(r, wv, lr, fs);
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n, input bit wv);
        for (int i = 0; i < n; i++) cycle(1'b0, wv, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; rd_line_req = 1'b0; rd_frame_start = 1'b0; m_wv = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        model_reset();
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_rd_line_ok", 32'(rd_line_ok), 32'd0);
        chk("reset_underrun_cnt", 32'(underrun_cnt), 32'd0);
        chk("reset_rd_base", 32'(rd_base), 32'd0);

        // First line fills bank 0, writer moves to bank 1
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(LINE_LEN, 1'b1);
        chk("t1_addr_after_line", 32'(wr_addr), 32'd1024);
        chk("t1_ready", 32'(wr_ready), 32'd1);

        // Both banks full -> stall; third request frees bank 0
        idle(LINE_LEN + 10, 1'b1);
        chk("t2_stall_ready", 32'(wr_ready), 32'd0);
        chk("t2_stall_en", 32'(wr_en), 32'd0);
        chk("t2_stall_addr", 32'(wr_addr), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_base1", 32'(rd_base), 32'd0);
        chk("t3_ok1", 32'(rd_line_ok), 32'd1);
        idle(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_base2", 32'(rd_base), 32'd0);
        chk("t2_still_stalled", 32'(wr_ready), 32'd0);
        idle(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_base3", 32'(rd_base), 32'd1024);
        chk("t3_ok3", 32'(rd_line_ok), 32'd1);
        chk("t2_resume_ready", 32'(wr_ready), 32'd1);
        chk("t2_resume_addr", 32'(wr_addr), 32'd0);
        idle(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_base4", 32'(rd_base), 32'd1024);

        // Underrun after reset, then recovery once a line lands
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_ok", 32'(rd_line_ok), 32'd0);
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_cnt", 32'(underrun_cnt), 32'd1);
        idle(LINE_LEN, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_ok_recover", 32'(rd_line_ok), 32'd1);
        chk("t4_base_recover", 32'(rd_base), 32'd0);

        // Frame start drops the active bank; next request finds nothing ready
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_ok_after_fs", 32'(rd_line_ok), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_ok_next", 32'(rd_line_ok), 32'd0);
        chk("t5_cnt", 32'(underrun_cnt), 32'd2);

        // Counter saturation and reset mid-line
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_cnt_sat", 32'(underrun_cnt), 32'd255);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(400, 1'b1);
        chk("t6_addr_mid", 32'(wr_addr), 32'd400);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_addr_after_rst", 32'(wr_addr), 32'd0);
        chk("t6_ready_after_rst", 32'(wr_ready), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_addr_next", 32'(wr_addr), 32'd1);

        // Random traffic: sparse and dense line requests, occasional frame starts
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9000; i++) begin
            bit wv, lr, fs;
            wv = ($urandom_range(0, 9) < 7);
            lr = ($urandom_range(0, (i < 5000) ? 199 : 39) == 0);
            fs = ($urandom_range(0, 999) == 0);
            cycle(1'b0, wv, lr, fs);
        end
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
